// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, legality helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_e;

   // Stores only have signed-size encodings; loads add the two unsigned variants.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!is_store) begin
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extracts/extends load data and merges sub-word store data into a word.
// Latency: purely combinational.
// Backpressure: none; the caller decides when results are used.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] rd_word_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] ld_data_o,
   output logic [XLEN-1:0] st_word_o
);

   logic [1:0]      lane;
   logic [4:0]      shamt;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] mask;

   // Lane is forced to natural alignment; misaligned requests that must fault never reach here.
   always_comb begin
      lane = addr_lo_i;
      if (funct3_i[1:0] == 2'b01) begin
         lane[0] = 1'b0;
      end else if (funct3_i[1:0] == 2'b10) begin
         lane = 2'b00;
      end
      shamt   = {lane, 3'b000};
      shifted = rd_word_i >> shamt;
   end

   // Load extraction with sign or zero extension.
   always_comb begin
      case (funct3_i)
         F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   ld_data_o = {24'd0, shifted[7:0]};
         F3_HU:   ld_data_o = {16'd0, shifted[15:0]};
         default: ld_data_o = rd_word_i;
      endcase
   end

   // Store merge: replace only the addressed byte/half of the current word.
   always_comb begin
      case (funct3_i[1:0])
         2'b00:   mask = 32'h0000_00FF;
         2'b01:   mask = 32'h0000_FFFF;
         default: mask = 32'hFFFF_FFFF;
      endcase
      st_word_o = (rd_word_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-only data memory; SB/SH done as read-modify-write.
// Latency: loads/SW/errors respond 1 cycle after accept; SB/SH occupy 2 cycles (st_done after the write).
// Backpressure: req_ready low during the RMW write cycle; pipeline holds its request.
// Build option LSU_MISALIGN_CHK_EN: fault misaligned half/word accesses instead of force-aligning them.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic [DATA_WIDTH-1:0] ld_data,
   output logic                  ld_valid,
   output logic                  st_done,
   output logic                  err,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
   logic                  ld_valid_q, ld_valid_d;
   logic                  st_done_q, st_done_d;
   logic                  err_q, err_d;

   logic                  accept;
   logic                  misalign;
   logic                  bad;
   logic                  is_word;
   logic [DATA_WIDTH-1:0] align_ld;
   logic [DATA_WIDTH-1:0] align_st;

   lsu_align u_align (
      .funct3_i  (req_funct3),
      .addr_lo_i (req_addr[1:0]),
      .rd_word_i (mem_rd_data),
      .wdata_i   (req_wdata),
      .ld_data_o (align_ld),
      .st_word_o (align_st)
   );

   // Request decode: acceptance, legality and (optionally) alignment faults.
   always_comb begin
      accept  = req_valid && (state_q == IDLE);
      is_word = (req_funct3[1:0] == 2'b10);
`ifdef LSU_MISALIGN_CHK_EN
      misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 (is_word && (req_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      bad = !f3_legal(req_we, req_funct3) || misalign;
   end

   // Next-state and next-output computation for the IDLE/RMW_WR controller.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_d     = word_q;
      ld_data_d  = ld_data_q;
      ld_valid_d = 1'b0;
      st_done_d  = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bad) begin
                  err_d = 1'b1;
               end else if (!req_we) begin
                  ld_data_d  = align_ld;
                  ld_valid_d = 1'b1;
               end else if (is_word) begin
                  st_done_d = 1'b1;
               end else begin
                  addr_d  = req_addr;
                  word_d  = align_st;
                  state_d = RMW_WR;
               end
            end
         end
         RMW_WR: begin
            st_done_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset clears everything, which also kills an in-flight RMW write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         word_q     <= '0;
         ld_data_q  <= '0;
         ld_valid_q <= 1'b0;
         st_done_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         ld_data_q  <= ld_data_d;
         ld_valid_q <= ld_valid_d;
         st_done_q  <= st_done_d;
         err_q      <= err_d;
      end
   end

   // Memory port: IDLE passes the request through; RMW_WR replays the latched merged word.
   always_comb begin
      req_ready   = (state_q == IDLE);
      mem_addr    = (state_q == RMW_WR) ? addr_q : req_addr;
      mem_wr_data = (state_q == RMW_WR) ? word_q : req_wdata;
      mem_wr_en   = (state_q == RMW_WR) || (accept && req_we && !bad && is_word);
   end

   assign ld_data  = ld_data_q;
   assign ld_valid = ld_valid_q;
   assign st_done  = st_done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word memory and a spec-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic [31:0] ld_data;
   logic        ld_valid;
   logic        st_done;
   logic        err;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   logic [31:0] mem     [16];
   logic [31:0] ref_mem [16];
   logic [31:0] exp_ld;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .ld_data     (ld_data),
      .ld_valid    (ld_valid),
      .st_done     (st_done),
      .err         (err),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data)
   );

   // 16-word data memory, combinational read, write on the clock edge.
   assign mem_rd_data = mem[mem_addr[5:2]];
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr[5:2]] <= mem_wr_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // ---------------- reference model (spec rules in plain arithmetic) ----------------
   function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
      logic ok;
      if (we) ok = (f3 <= 3'd2);
      else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
`ifdef LSU_MISALIGN_CHK_EN
      if (f3[1:0] == 2'b01 && (a % 2) != 0) ok = 1'b0;
      if (f3 == 3'd2 && (a % 4) != 0) ok = 1'b0;
`else
      if (a == 32'hFFFF_FFFF) ok = ok; // address alignment is forced, never faulted
`endif
      return ok;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] w, v;
      w = ref_mem[(a / 4) % 16];
      v = w;
      if (f3 == 3'd0 || f3 == 3'd4) begin
         v = (w >> (8 * (a % 4))) % 256;
         if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
         v = (w >> (16 * ((a / 2) % 2))) % 65536;
         if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] wd);
      logic [31:0] old, mask;
      int          sh;
      old = ref_mem[(a / 4) % 16];
      if (f3 == 3'd0) begin
         mask = 32'd255;   sh = 8 * (a % 4);
      end else if (f3 == 3'd1) begin
         mask = 32'd65535; sh = 16 * ((a / 2) % 2);
      end else begin
         return wd;
      end
      return (old & ~(mask << sh)) | ((wd & mask) << sh);
   endfunction

   // One request presented for a single accept cycle, then all response cycles checked.
   task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      logic        ok, sub, wst;
      logic [31:0] nw;
      ok  = m_legal(we, f3, a);
      sub = we && ok && (f3 != 3'd2);
      wst = we && ok && (f3 == 3'd2);
      nw  = 32'd0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      #1;
      chk("acc_ready", {31'd0, req_ready}, 32'd1);
      chk("acc_wr_en", {31'd0, mem_wr_en}, {31'd0, wst});
      if (wst) chk("sw_wr_data", mem_wr_data, wd);
      if (!we && ok) exp_ld = m_load(f3, a);
      if (sub) nw = m_store(f3, a, wd);
      if (wst) ref_mem[(a / 4) % 16] = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (sub) begin
         chk("rmw_ready", {31'd0, req_ready}, 32'd0);
         chk("rmw_wr_en", {31'd0, mem_wr_en}, 32'd1);
         chk("rmw_addr", mem_addr, a);
         chk("rmw_wr_data", mem_wr_data, nw);
         chk("rmw_no_done_yet", {31'd0, st_done}, 32'd0);
         ref_mem[(a / 4) % 16] = nw;
         @(posedge clk); #1;
      end
      chk("ld_valid", {31'd0, ld_valid}, {31'd0, !we && ok});
      chk("st_done", {31'd0, st_done}, {31'd0, we && ok});
      chk("err", {31'd0, err}, {31'd0, !ok});
      chk("ld_data", ld_data, exp_ld);
      @(posedge clk); #1;
      chk("pulse_len", {29'd0, ld_valid, st_done, err}, 32'd0);
      chk("idle_wr_en", {31'd0, mem_wr_en}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] saved;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      for (int i = 0; i < 16; i++) begin
         mem[i] = 32'd0; ref_mem[i] = 32'd0;
      end
      exp_ld = 32'd0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_outs", {28'd0, ld_valid, st_done, err, mem_wr_en}, 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Sub-word loads from a known word.
      do_op(1'b1, 3'd2, 32'h0, 32'h8899AABB);
      do_op(1'b0, 3'd0, 32'h1, 32'd0);  chk("lb_const",  ld_data, 32'hFFFFFFAA);
      do_op(1'b0, 3'd4, 32'h1, 32'd0);  chk("lbu_const", ld_data, 32'h000000AA);
      do_op(1'b0, 3'd1, 32'h2, 32'd0);  chk("lh_const",  ld_data, 32'hFFFF8899);

      // SW then SB merge.
      do_op(1'b1, 3'd2, 32'h4, 32'h12345678);
      do_op(1'b1, 3'd0, 32'h6, 32'h000000EE);
      do_op(1'b0, 3'd2, 32'h4, 32'd0);  chk("sb_merge_const", ld_data, 32'h12EE5678);

      // Back-to-back SH with req_valid held across the busy cycle.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h8; req_wdata = 32'hBEEF;
      @(posedge clk); #1;
      req_addr = 32'hA; req_wdata = 32'hCAFE;
      chk("b2b_busy_ready", {31'd0, req_ready}, 32'd0);
      chk("b2b_wr1_en", {31'd0, mem_wr_en}, 32'd1);
      chk("b2b_wr1_data", mem_wr_data, 32'h0000BEEF);
      @(posedge clk); #1;
      chk("b2b_ready_back", {31'd0, req_ready}, 32'd1);
      chk("b2b_done1", {31'd0, st_done}, 32'd1);
      chk("b2b_idle_no_wr", {31'd0, mem_wr_en}, 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b2b_second_acc", {31'd0, req_ready}, 32'd0);
      chk("b2b_wr2_data", mem_wr_data, 32'hCAFEBEEF);
      @(posedge clk); #1;
      chk("b2b_done2", {31'd0, st_done}, 32'd1);
      ref_mem[2] = 32'hCAFEBEEF;
      do_op(1'b0, 3'd2, 32'h8, 32'd0);  chk("b2b_const", ld_data, 32'hCAFEBEEF);

      // Illegal funct3 load, illegal store funct3, misaligned SW.
      do_op(1'b0, 3'd3, 32'h0, 32'd0);
      do_op(1'b1, 3'd4, 32'h0, 32'h55);
      do_op(1'b1, 3'd2, 32'h5, 32'hA5A5A5A5);
      do_op(1'b0, 3'd2, 32'h4, 32'd0);
`ifdef LSU_MISALIGN_CHK_EN
      chk("sw_mis_const", ld_data, 32'h12EE5678);
`else
      chk("sw_mis_const", ld_data, 32'hA5A5A5A5);
`endif

      // Reset during RMW_WR aborts the write.
      saved = ref_mem[4];
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'h77;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rst_rmw_wr_en", {31'd0, mem_wr_en}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
      chk("rst_abort_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      exp_ld = 32'd0;
      do_op(1'b0, 3'd2, 32'h10, 32'd0); chk("rst_abort_mem", ld_data, saved);

      // Randomized mix against the reference model.
      for (int i = 0; i < 120; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) :
              (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
         if (!we && f3 == 3'd3) f3 = 3'd4;
         a = 32'($urandom_range(0, 63));
         do_op(we, f3, a, $urandom);
      end

      // Final memory sweep through the unit.
      for (int i = 0; i < 16; i++) begin
         do_op(1'b0, 3'd2, 32'(i * 4), 32'd0);
         chk("sweep_mem", mem[i], ref_mem[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
